// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 program loader: loader FSM states,
// the default frame sync byte and the instruction word width.
package chip8_pkg;

  localparam int         WORD_W    = 16;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_WRITE = 3'd4,
    ST_CSUM  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Framed byte stream -> 16-bit program memory writes; holds the CPU until a good frame lands.
// Latency: mem_we pulses in the cycle after the LO-byte handshake; flags update the cycle after CSUM.
// Backpressure: rx_ready drops only in the WRITE cycle, so at most one word per 3 cycles.
module program_loader
  import chip8_pkg::*;
#(
  parameter int         ADDR_W = 8,
  parameter logic [7:0] SYNC   = SYNC_BYTE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic                cpu_hold,
  output logic                done,
  output logic                error
);

  loader_state_t       state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     wcnt_q;     // words written so far in this frame
  logic [ADDR_W:0]     nwords_q;   // frame length; one extra bit so LEN=0 can mean 2^ADDR_W
  logic [7:0]          sum_q;
  logic [7:0]          hi_q;
  logic [WORD_W-1:0]   wdata_q;
  logic                we_q;
  logic                ready_q;
  logic                hold_q;
  logic                done_q;
  logic                error_q;

  logic                xfer;
  logic [ADDR_W:0]     nwords_d;
  logic [ADDR_W:0]     wcnt_d;
  logic [7:0]          sum_d;

  assign xfer     = rx_valid && ready_q;
  assign nwords_d = (rx_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W+1)'(rx_data);
  assign wcnt_d   = wcnt_q + 1'b1;
  assign sum_d    = sum_q + rx_data;

  // Loader FSM: frame parsing, checksum accumulation and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wcnt_q   <= '0;
      nwords_q <= '0;
      sum_q    <= '0;
      hi_q     <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      ready_q  <= 1'b0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (xfer && rx_data == SYNC) begin
            // A new frame invalidates whatever the previous one reported.
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            state_q <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (xfer) begin
            nwords_q <= nwords_d;
            addr_q   <= '0;
            wcnt_q   <= '0;
            sum_q    <= '0;
            state_q  <= ST_HI;
          end
        end
        ST_HI: begin
          if (xfer) begin
            hi_q    <= rx_data;
            sum_q   <= sum_d;
            state_q <= ST_LO;
          end
        end
        ST_LO: begin
          if (xfer) begin
            sum_q   <= sum_d;
            wdata_q <= {hi_q, rx_data};
            we_q    <= 1'b1;
            ready_q <= 1'b0;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Address wraps naturally on a full-size frame; the word counter decides the end.
          we_q    <= 1'b0;
          ready_q <= 1'b1;
          addr_q  <= addr_q + 1'b1;
          wcnt_q  <= wcnt_d;
          state_q <= (wcnt_d == nwords_q) ? ST_CSUM : ST_HI;
        end
        ST_CSUM: begin
          if (xfer) begin
            if (rx_data == sum_q) begin
              done_q <= 1'b1;
              hold_q <= 1'b0;
            end else begin
              error_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_ready  = ready_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: randomized framed streams against a
// frame-level reference model, plus directed good/bad/garbage/full/reset cases.
module tb_program_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [23:0] wq_t[$];

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  wq_t         obs_w;
  logic [15:0] mem_img [256];
  logic [15:0] snap_img [256];
  logic        prev_we;

  // Reference flags carried between frames.
  logic m_done, m_err, m_hold;

  program_loader #(.ADDR_W(8), .SYNC(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: records every write, mirrors memory, checks the WRITE-cycle rules.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_w.push_back({mem_addr, mem_wdata});
      mem_img[mem_addr] = mem_wdata;
      check("ready_low_in_write", {31'd0, rx_ready}, 32'd0);
      check("we_single_cycle", {31'd0, prev_we}, 32'd0);
    end
    prev_we = mem_we;
  end

  // Frame-level model: scan for SYNC, read LEN, pair data bytes into words, compare the sum.
  task automatic model(input bq_t b, output wq_t w);
    int i;
    int n;
    logic [7:0] sum;
    w = {};
    i = 0;
    while (i < b.size()) begin
      if (b[i] != 8'hA5) begin
        i++;
      end else begin
        m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1;
        if (i + 1 >= b.size()) break;
        n = (b[i+1] == 8'd0) ? 256 : int'(b[i+1]);
        i += 2;
        sum = 8'd0;
        for (int k = 0; k < n && i + 1 < b.size(); k++) begin
          w.push_back({k[7:0], b[i], b[i+1]});
          sum = sum + b[i] + b[i+1];
          i += 2;
        end
        if (i >= b.size()) break;
        if (b[i] == sum) begin m_done = 1'b1; m_hold = 1'b0; end
        else m_err = 1'b1;
        i++;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    int waited;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    repeat (g) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    waited = 0;
    while (rx_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("handshake_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_stream(input string tag, input bq_t b, input int maxgap);
    wq_t exp_w;
    int  nchk;
    obs_w = {};
    model(b, exp_w);
    foreach (b[i]) send_byte(b[i], maxgap);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_nwrites"}, obs_w.size(), exp_w.size());
    nchk = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
    for (int i = 0; i < nchk; i++)
      check({tag, "_write"}, {8'd0, obs_w[i]}, {8'd0, exp_w[i]});
    check({tag, "_done"},  {31'd0, done},     {31'd0, m_done});
    check({tag, "_error"}, {31'd0, error},    {31'd0, m_err});
    check({tag, "_hold"},  {31'd0, cpu_hold}, {31'd0, m_hold});
  endtask

  function automatic bq_t make_frame(input bq_t words_b, input logic [7:0] len, input logic bad);
    bq_t f;
    logic [7:0] s;
    s = 8'd0;
    f = {8'hA5, len};
    foreach (words_b[i]) begin
      f.push_back(words_b[i]);
      s = s + words_b[i];
    end
    f.push_back(bad ? s ^ 8'h5A : s);
    return f;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"},  {31'd0, rx_ready},  32'd0);
    check({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
    check({tag, "_mem_addr"},  {24'd0, mem_addr},  32'd0);
    check({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
    check({tag, "_cpu_hold"},  {31'd0, cpu_hold},  32'd1);
    check({tag, "_done"},      {31'd0, done},      32'd0);
    check({tag, "_error"},     {31'd0, error},     32'd0);
  endtask

  initial begin
    bq_t s;
    bq_t d;
    int  mism;
    int  n;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; prev_we = 1'b0;
    for (int i = 0; i < 256; i++) mem_img[i] = 16'h0;
    m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'd0, rx_ready}, 32'd1);

    // Good frame, bad checksum, leading garbage.
    s = {8'hA5, 8'h02, 8'h61, 8'h05, 8'h71, 8'h01, 8'hD8};
    run_stream("good", s, 0);
    check("good_done_abs", {31'd0, done}, 32'd1);
    s = {8'hA5, 8'h02, 8'h61, 8'h05, 8'h71, 8'h01, 8'h00};
    run_stream("badcsum", s, 0);
    check("bad_error_abs", {31'd0, error}, 32'd1);
    s = {8'h00, 8'hFF, 8'hA5, 8'h02, 8'h61, 8'h05, 8'h71, 8'h01, 8'hD8};
    run_stream("garbage", s, 2);

    // Full 256-word frame, back-to-back, then again with random gaps: identical image.
    d = {};
    for (int a = 0; a < 256; a++) begin d.push_back(a[7:0]); d.push_back(a[7:0]); end
    s = make_frame(d, 8'h00, 1'b0);
    run_stream("full_b2b", s, 0);
    check("full_b2b_done_abs", {31'd0, done}, 32'd1);
    check("full_addr_wrap", {24'd0, mem_addr}, 32'd0);
    for (int i = 0; i < 256; i++) snap_img[i] = mem_img[i];
    for (int i = 0; i < 256; i++) mem_img[i] = 16'h0;
    run_stream("full_gaps", s, 3);
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem_img[i] !== snap_img[i]) mism++;
    check("image_identical", mism, 0);

    // Randomized frames with optional garbage, random lengths, good/bad checksums.
    for (int t = 0; t < 20; t++) begin
      s = {};
      if ($urandom_range(0, 1) == 1) s.push_back(8'($urandom_range(0, 8'hA4)));
      n = $urandom_range(1, 9);
      d = {};
      for (int k = 0; k < 2 * n; k++) d.push_back(8'($urandom));
      s = {s, make_frame(d, n[7:0], $urandom_range(0, 2) == 0)};
      run_stream("rand", s, $urandom_range(0, 3));
    end

    // Reset after the first HI byte: no write, reset values, then a good frame loads.
    obs_w = {};
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h61, 0);
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    @(negedge clk);
    check("midrst_nowrite", obs_w.size(), 0);
    m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1;
    s = {8'hA5, 8'h02, 8'h61, 8'h05, 8'h71, 8'h01, 8'hD8};
    run_stream("after_rst", s, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
